// File: rtl/spikifier_pkg.sv
// Shared constants and width helpers for the spikifier array.
// Optional bipolar build: define SPIKIFIER_BIPOLAR_EN.
package spikifier_pkg;

   localparam int N_DEF          = 4;
   localparam int W_DEF          = 8;
   localparam int REFRACT_DEF    = 0;
   localparam int LEAK_SHIFT_DEF = 0;

   // Two guard bits keep residue plus one sample in range.
   function automatic int acc_w(input int w);
      return w + 2;
   endfunction

   function automatic int rcnt_w(input int r);
      return (r < 1) ? 1 : $clog2(r + 1);
   endfunction

endpackage

// File: rtl/spikifier_chan.sv
// One integrate-and-fire channel with leak and refractory counter.
// Optional bipolar build: define SPIKIFIER_BIPOLAR_EN.
module spikifier_chan
   import spikifier_pkg::*;
#(
   parameter int W          = W_DEF,
   parameter int REFRACT    = REFRACT_DEF,
   parameter int LEAK_SHIFT = LEAK_SHIFT_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   input  logic [W-1:0] sample,
   input  logic [W-1:0] th,
`ifdef SPIKIFIER_BIPOLAR_EN
   output logic         q_neg,
`endif
   output logic         q
);

   localparam int AW = acc_w(W);
   localparam int RW = rcnt_w(REFRACT);

   logic signed [AW-1:0] acc;
   logic signed [AW-1:0] sx;
   logic signed [AW-1:0] thx;
   logic signed [AW-1:0] lk;
   logic signed [AW-1:0] a;
   logic        [RW-1:0] rcnt;
   logic                 pos;
   logic                 neg;

   always_comb begin
`ifdef SPIKIFIER_BIPOLAR_EN
      sx  = {{2{sample[W-1]}}, sample};
`else
      sx  = {2'b00, sample};
`endif
      thx = {2'b00, th};
      lk  = (LEAK_SHIFT == 0) ? '0 : (acc >>> LEAK_SHIFT);
      a   = acc - lk + sx;
      pos = (a >= thx);
`ifdef SPIKIFIER_BIPOLAR_EN
      neg = (a <= -thx);
`else
      neg = 1'b0;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc   <= '0;
         rcnt  <= '0;
         q     <= 1'b0;
`ifdef SPIKIFIER_BIPOLAR_EN
         q_neg <= 1'b0;
`endif
      end else begin
         q     <= 1'b0;
`ifdef SPIKIFIER_BIPOLAR_EN
         q_neg <= 1'b0;
`endif
         if (in_valid) begin
            if (rcnt != '0) begin
               rcnt <= rcnt - RW'(1);
            end else if (pos) begin
               acc  <= a - thx;
               rcnt <= RW'(REFRACT);
               q    <= 1'b1;
            end else if (neg) begin
               acc  <= a + thx;
               rcnt <= RW'(REFRACT);
`ifdef SPIKIFIER_BIPOLAR_EN
               q_neg <= 1'b1;
`endif
            end else begin
               acc  <= a;
            end
         end
      end
   end

endmodule

// File: rtl/spikifier_array.sv
// N-channel spikifier: slices samples and shares the threshold.
// Optional bipolar build: define SPIKIFIER_BIPOLAR_EN.
module spikifier_array
   import spikifier_pkg::*;
#(
   parameter int N          = N_DEF,
   parameter int W          = W_DEF,
   parameter int REFRACT    = REFRACT_DEF,
   parameter int LEAK_SHIFT = LEAK_SHIFT_DEF
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   input  logic [N*W-1:0] in_sample,
   input  logic [W-1:0]   thresh,
`ifdef SPIKIFIER_BIPOLAR_EN
   output logic [N-1:0]   q_neg,
`endif
   output logic [N-1:0]   q
);

   logic [W-1:0] th;

   // A zero threshold would fire on nothing useful; clamp to 1.
   assign th = (thresh == '0) ? W'(1) : thresh;

   for (genvar c = 0; c < N; c++) begin : g_ch
      spikifier_chan #(
         .W          (W),
         .REFRACT    (REFRACT),
         .LEAK_SHIFT (LEAK_SHIFT)
      ) u_chan (
         .clk      (clk),
         .rst      (rst),
         .in_valid (in_valid),
         .sample   (in_sample[c*W +: W]),
         .th       (th),
`ifdef SPIKIFIER_BIPOLAR_EN
         .q_neg    (q_neg[c]),
`endif
         .q        (q[c])
      );
   end

endmodule
